div_issue_collect: RTL and testbench

- Handshake front/back end for the 4-stage pipelined 16/8 restoring divider (A[15:0] / B[7:0] -> Q0[7:0]).
- Accepts valid/ready operand requests and drives the divider operand inputs.
- Tracks in-flight operations with a valid/tag shift pipeline matched to divider latency and captures each Q0 into an output FIFO.
- Uses credit-based issue: the divider pipeline cannot stall, so results are never dropped.

---
 rtl/div_issue_collect.sv | 132 +++++++++++++
 tb/tb_div_issue_collect.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_collect.sv
// Issue/collect wrapper for the 4-stage pipelined 16/8 divider: credit-based issue, tag pipe, show-ahead result FIFO.
// Optional macro DIVQ_OVF_DETECT_EN adds the quotient-overflow flag to each result.
module div_issue_collect #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned AW      = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_a,
   input  logic [7:0]    in_b,
   output logic [15:0]   div_a,
   output logic [7:0]    div_b,
   input  logic [7:0]    div_q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_q,
   output logic          out_dz,
   output logic          out_ovf,
   output logic [AW:0]   inflight,
   output logic          busy
);

   localparam int unsigned CW = AW + 2;

   logic               fire_in;
   logic               push;
   logic               pop;
   logic               push_dz;
   logic [7:0]         push_q;
   logic [LATENCY-1:0] v_pipe;
   logic [LATENCY-1:0] dz_pipe;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      rd_next;
   logic [AW:0]        count;
   logic [AW:0]        count_next;
   logic [AW:0]        inflight_next;
   logic               head_from_push;
   logic [7:0]         mem_q  [DEPTH];
   logic               mem_dz [DEPTH];

   // Credit: every accepted op already owns a FIFO slot, so the non-stallable divider never overflows it
   assign in_ready = rst_n & ((CW'(count) + CW'(inflight)) < CW'(DEPTH));
   assign fire_in  = in_valid & in_ready;
   assign div_a    = fire_in ? in_a : 16'h0;
   assign div_b    = fire_in ? in_b : 8'h0;

   assign push    = v_pipe[LATENCY-1];
   assign push_dz = dz_pipe[LATENCY-1];
   assign push_q  = push_dz ? 8'hFF : div_q;
   assign pop     = out_valid & out_ready;

   always_comb begin
      rd_next        = rd_ptr + AW'(pop);
      count_next     = count + (AW+1)'(push) - (AW+1)'(pop);
      inflight_next  = inflight + (AW+1)'(fire_in) - (AW+1)'(push);
      // FIFO drains to nothing this edge, so the new head is the entry being pushed
      head_from_push = (count == (AW+1)'(pop));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_pipe    <= '0;
         dz_pipe   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         inflight  <= '0;
         out_valid <= 1'b0;
         out_q     <= 8'h0;
         out_dz    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         v_pipe    <= {v_pipe[LATENCY-2:0], fire_in};
         dz_pipe   <= {dz_pipe[LATENCY-2:0], fire_in & (in_b == 8'h0)};
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr    <= rd_next;
         count     <= count_next;
         inflight  <= inflight_next;
         out_valid <= (count_next != '0);
         busy      <= (count_next != '0) | (inflight_next != '0);
         if (count_next != '0) begin
            out_q  <= head_from_push ? push_q  : mem_q[rd_next];
            out_dz <= head_from_push ? push_dz : mem_dz[rd_next];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr]  <= push_q;
         mem_dz[wr_ptr] <= push_dz;
      end
   end

`ifdef DIVQ_OVF_DETECT_EN
   logic               ovf_calc;
   logic [LATENCY-1:0] ovf_pipe;
   logic               mem_ovf [DEPTH];

   // Quotient exceeds 8 bits exactly when the dividend's high byte is not below the divisor
   assign ovf_calc = (in_b != 8'h0) & (in_a[15:8] >= in_b);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_pipe <= '0;
         out_ovf  <= 1'b0;
      end else begin
         ovf_pipe <= {ovf_pipe[LATENCY-2:0], fire_in & ovf_calc};
         if (count_next != '0)
            out_ovf <= head_from_push ? ovf_pipe[LATENCY-1] : mem_ovf[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_ovf[wr_ptr] <= ovf_pipe[LATENCY-1];
   end
`else
   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst_n)
         assert (!(push && (count == (AW+1)'(DEPTH))));
   end

endmodule

// File: tb/tb_div_issue_collect.sv
// Self-checking bench for div_issue_collect with a behavioural divider and an in-order result scoreboard.
module tb_div_issue_collect;

   localparam int unsigned LATENCY = 4;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned AW      = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_a;
   logic [7:0]    in_b;
   logic [15:0]   div_a;
   logic [7:0]    div_b;
   logic [7:0]    div_q;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_q;
   logic          out_dz;
   logic          out_ovf;
   logic [AW:0]   inflight;
   logic          busy;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   typedef struct {
      logic [7:0] q;
      logic       dz;
      logic       ovf;
      int         rdy;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] dpipe [LATENCY];

   always #5 clk = ~clk;

   div_issue_collect #(.LATENCY(LATENCY), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_b(div_b), .div_q(div_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
      .out_dz(out_dz), .out_ovf(out_ovf), .inflight(inflight), .busy(busy)
   );

   function automatic logic [7:0] div_model(input logic [15:0] a, input logic [7:0] b);
      if (b == 8'h0)
         return 8'h5A;
      return 8'(int'(a) / int'(b));
   endfunction

   // Behavioural divider: quotient appears LATENCY edges after the operands are sampled
   always @(posedge clk) begin
      dpipe[0] <= div_model(div_a, div_b);
      for (int i = 1; i < LATENCY; i++)
         dpipe[i] <= dpipe[i-1];
      cyc <= cyc + 1;
   end
   assign div_q = dpipe[LATENCY-1];

   function automatic exp_t make_exp(input logic [15:0] a, input logic [7:0] b, input int rdy);
      exp_t e;
      e.dz  = (b == 8'h0);
      e.q   = e.dz ? 8'hFF : 8'(int'(a) / int'(b));
`ifdef DIVQ_OVF_DETECT_EN
      e.ovf = !e.dz && ((int'(a) / int'(b)) > 255);
`else
      e.ovf = 1'b0;
`endif
      e.rdy = rdy;
      return e;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at negedge+1, check against the model, update model, advance to next negedge
   task automatic step(output bit fired);
      bit   popv;
      int   nready;
      exp_t e;
      #1;
      if (chk_en) begin
         nready = 0;
         foreach (exp_q[i]) if (exp_q[i].rdy <= cyc) nready++;
         check("in_ready",  16'(in_ready),  16'(rst_n && (exp_q.size() < DEPTH)));
         check("out_valid", 16'(out_valid), 16'(nready > 0));
         check("inflight",  16'(inflight),  16'(exp_q.size() - nready));
         check("busy",      16'(busy),      16'(exp_q.size() != 0));
      end
      fired = in_valid && in_ready;
      popv  = out_valid && out_ready;
      if (popv && rst_n) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL pop_unexpected: observed q=%0h with no result outstanding", out_q);
         end else begin
            e = exp_q.pop_front();
            check("res_q",   16'(out_q),   16'(e.q));
            check("res_dz",  16'(out_dz),  16'(e.dz));
            check("res_ovf", 16'(out_ovf), 16'(e.ovf));
         end
      end
      if (!rst_n)
         exp_q.delete();
      else if (fired)
         exp_q.push_back(make_exp(in_a, in_b, cyc + 1 + LATENCY));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      bit f;
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || busy) && n < 60) begin
         step(f);
         n++;
      end
      check("drain_busy",     16'(busy),     16'h0);
      check("drain_inflight", 16'(inflight), 16'h0);
      check("drain_pending",  16'(exp_q.size()), 16'h0);
   endtask

   task automatic issue_one(input logic [15:0] a, input logic [7:0] b, input string tag);
      bit f;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      step(f);
      check(tag, 16'(f), 16'h1);
      in_valid = 1'b0;
   endtask

   function automatic logic [7:0] rand_b();
      if ($urandom_range(0, 7) == 0)
         return 8'h0;
      return 8'($urandom_range(1, 255));
   endfunction

   initial begin
      bit f;
      int lat;
      int acc;
      int n;

      rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 8'h0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready",  16'(in_ready),  16'h0);
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_out_q",     16'(out_q),     16'h0);
      check("rst_out_dz",    16'(out_dz),    16'h0);
      check("rst_out_ovf",   16'(out_ovf),   16'h0);
      check("rst_inflight",  16'(inflight),  16'h0);
      check("rst_busy",      16'(busy),      16'h0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // Single op and its latency
      out_ready = 1'b1;
      issue_one(16'h03E8, 8'h07, "single_accept");
      lat = 0;
      while (!out_valid && lat < 10) begin
         step(f);
         lat++;
      end
      check("single_latency", 16'(lat), 16'(LATENCY));
      check("single_q", 16'(out_q), 16'h008E);
      drain();

      // Overflowing quotient, then divide by zero
      issue_one(16'h1234, 8'h12, "ovf_accept");
      drain();
      check("ovf_hold_q", 16'(out_q), 16'h0002);
`ifdef DIVQ_OVF_DETECT_EN
      check("ovf_hold_flag", 16'(out_ovf), 16'h1);
`else
      check("ovf_hold_flag", 16'(out_ovf), 16'h0);
`endif
      issue_one(16'h00FF, 8'h00, "dz_accept");
      drain();
      check("dz_hold_q",   16'(out_q),  16'h00FF);
      check("dz_hold_dz",  16'(out_dz), 16'h1);
      check("dz_hold_ovf", 16'(out_ovf), 16'h0);

      // Backpressure: only DEPTH credits available
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 14; i++) begin
         in_valid = (acc < 10);
         in_a     = 16'(1000 + acc * 377);
         in_b     = 8'(3 + acc);
         step(f);
         if (f) acc++;
      end
      check("bp_accepted", 16'(acc), 16'(DEPTH));
      #1;
      check("bp_in_ready", 16'(in_ready), 16'h0);
      @(negedge clk);
      drain();
      #1;
      check("bp_ready_back", 16'(in_ready), 16'h1);
      @(negedge clk);

      // Streaming random ops with random backpressure
      acc = 0;
      n   = 0;
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = rand_b();
      while (acc < 20 && n < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         step(f);
         n++;
         if (f) begin
            acc++;
            in_a = 16'($urandom);
            in_b = rand_b();
         end
      end
      check("stream_issued", 16'(acc), 16'd20);
      drain();

      // Reset while ops are in flight
      out_ready = 1'b1;
      issue_one(16'h4000, 8'h41, "rstmid_op0");
      issue_one(16'h0500, 8'h0A, "rstmid_op1");
      issue_one(16'h0777, 8'h00, "rstmid_op2");
      rst_n = 1'b0;
      step(f);
      rst_n = 1'b1;
      check("rstmid_inflight", 16'(inflight), 16'h0);
      check("rstmid_busy",     16'(busy),     16'h0);
      for (int i = 0; i < 8; i++) begin
         check("rstmid_no_valid", 16'(out_valid), 16'h0);
         step(f);
      end
      issue_one(16'h2710, 8'h64, "rstmid_new");
      drain();
      check("rstmid_new_q", 16'(out_q), 16'h0064);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
